// File: rtl/digit_column_streamer.sv
// Walks the 7-seg-to-pixel decoder over a frame of glyphs and streams the
// returned column bytes to the SSD1306 transport in horizontal-addressing order.
module digit_column_streamer #(
  parameter int NUM_DIGITS = 6
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [8*NUM_DIGITS-1:0] segments_in,
  output logic [7:0]              dec_segments,
  output logic [3:0]              dec_index_x,
  output logic [1:0]              dec_index_y,
  input  logic [7:0]              dec_pixels,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    busy,
  output logic                    done
);

  localparam logic [3:0] LAST_DIGIT = 4'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, FETCH, SEND, FINISH} state_t;

  state_t                  state;
  logic [8*NUM_DIGITS-1:0] snapshot;
  logic [1:0]              page;
  logic [3:0]              digit;
  logic [3:0]              x;
  logic                    last_byte;

  assign dec_index_x = x;
  assign dec_index_y = page;
  assign last_byte   = (page == 2'd3) && (digit == LAST_DIGIT) && (x == 4'd15);

  // Explicit mux keeps the digit select inside the snapshot for any NUM_DIGITS.
  always_comb begin
    dec_segments = 8'h00;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit == 4'(i)) dec_segments = snapshot[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      snapshot <= '0;
      page     <= 2'd0;
      digit    <= 4'd0;
      x        <= 4'd0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            snapshot <= segments_in;
            page     <= 2'd0;
            digit    <= 4'd0;
            x        <= 4'd0;
            busy     <= 1'b1;
            state    <= FETCH;
          end
        end
        FETCH: begin
          tx_data  <= dec_pixels;
          tx_valid <= 1'b1;
          state    <= SEND;
        end
        SEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            x        <= x + 4'd1;
            // x wraps into digit, digit wraps into page; all wrap to 0 after the last byte.
            if (x == 4'd15) begin
              if (digit == LAST_DIGIT) begin
                digit <= 4'd0;
                page  <= page + 2'd1;
              end else begin
                digit <= digit + 4'd1;
              end
            end
            if (last_byte) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              state <= FETCH;
            end
          end
        end
        FINISH: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_column_streamer.sv
// Scoreboard bench: stimulus pushes expected bytes, negedge monitors pop and compare.
module tb_digit_column_streamer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [47:0] segments_in;
  logic [7:0]  dec_segments;
  logic [3:0]  dec_index_x;
  logic [1:0]  dec_index_y;
  logic [7:0]  dec_pixels;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;

  logic        start1;
  logic [7:0]  segments_in1;
  logic [7:0]  dec_segments1;
  logic [3:0]  dec_index_x1;
  logic [1:0]  dec_index_y1;
  logic [7:0]  dec_pixels1;
  logic [7:0]  tx_data1;
  logic        tx_valid1;
  logic        tx_ready1;
  logic        busy1;
  logic        done1;

  int n_checks = 0;
  int n_fail = 0;
  int cycle = 0;
  int accept_count = 0;
  int done_count = 0;
  int last_accept_cycle = -10;
  int accept1_count = 0;
  int done1_count = 0;
  bit stall_en = 1'b0;
  bit prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] exp_q[$];
  logic [7:0] exp1_q[$];

  localparam logic [47:0] DIGITS_012345 = {8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F};
  localparam logic [47:0] DIGITS_ALT    = {8'h7F, 8'h77, 8'h39, 8'h5E, 8'h79, 8'h71};

  // Decoder reference: blank glyph is all dark, lit segments give a position-dependent byte.
  function automatic logic [7:0] decode(input logic [7:0] seg, input logic [3:0] xi, input logic [1:0] yi);
    if (seg == 8'h00) return 8'h00;
    return seg ^ {xi, 2'b00, yi};
  endfunction

  function automatic logic [7:0] expected_byte(input logic [47:0] segs, input int n, input int k);
    int page, digit, xi;
    logic [7:0] seg;
    page  = k / (16 * n);
    digit = (k / 16) % n;
    xi    = k % 16;
    seg   = segs[8*digit +: 8];
    return decode(seg, 4'(xi), 2'(page));
  endfunction

  assign dec_pixels  = decode(dec_segments, dec_index_x, dec_index_y);
  assign dec_pixels1 = decode(dec_segments1, dec_index_x1, dec_index_y1);

  digit_column_streamer #(.NUM_DIGITS(6)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .segments_in(segments_in),
    .dec_segments(dec_segments), .dec_index_x(dec_index_x), .dec_index_y(dec_index_y),
    .dec_pixels(dec_pixels), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done)
  );

  digit_column_streamer #(.NUM_DIGITS(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .segments_in(segments_in1),
    .dec_segments(dec_segments1), .dec_index_x(dec_index_x1), .dec_index_y(dec_index_y1),
    .dec_pixels(dec_pixels1), .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
    .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [47:0] segs);
    @(posedge clk);
    #1;
    segments_in = segs;
    start = 1'b1;
    for (int k = 0; k < 384; k++) exp_q.push_back(expected_byte(segs, 6, k));
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic applyStimulus1(input logic [7:0] seg);
    logic [47:0] segs;
    segs = {40'h0, seg};
    @(posedge clk);
    #1;
    segments_in1 = seg;
    start1 = 1'b1;
    for (int k = 0; k < 64; k++) exp1_q.push_back(expected_byte(segs, 1, k));
    @(posedge clk);
    #1;
    start1 = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int c = 0; c < budget && done_count < target; c++) @(posedge clk);
    checkOutput("frame_done_seen", done_count, target);
  endtask

  task automatic wait_accepts(input int target, input int budget);
    for (int c = 0; c < budget && accept_count < target; c++) @(posedge clk);
    checkOutput("accept_progress", 32'(accept_count >= target), 1);
  endtask

  // Transport side: always ready, or a coin flip each cycle when stalling.
  initial begin
    tx_ready = 1'b1;
    tx_ready1 = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tx_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor for the six-digit instance.
  initial begin
    logic [7:0] expv;
    forever begin
      @(negedge clk);
      cycle++;
      if (!reset_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          checkOutput("stall_valid_held", tx_valid, 1);
          checkOutput("stall_data_held", tx_data, prev_data);
        end
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL unexpected_byte: got 0x%0h with empty scoreboard", tx_data);
          end else begin
            expv = exp_q.pop_front();
            checkOutput($sformatf("byte_%0d", accept_count), tx_data, expv);
          end
          accept_count++;
          last_accept_cycle = cycle;
        end
        if (done) begin
          checkOutput("done_one_after_last_accept", cycle - last_accept_cycle, 1);
          done_count++;
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
      end
    end
  end

  // Monitor for the single-digit instance.
  initial begin
    logic [7:0] expv;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (tx_valid1 && tx_ready1) begin
          if (exp1_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL unexpected_byte1: got 0x%0h with empty scoreboard", tx_data1);
          end else begin
            expv = exp1_q.pop_front();
            checkOutput($sformatf("byte1_%0d", accept1_count), tx_data1, expv);
          end
          accept1_count++;
        end
        if (done1) done1_count++;
      end
    end
  end

  initial begin
    int base;
    reset_n = 1'b1;
    start = 1'b0;
    start1 = 1'b0;
    segments_in = '0;
    segments_in1 = '0;
    #1 reset_n = 1'b0;
    #12;
    checkOutput("reset_outputs", {tx_data, tx_valid, busy, done, dec_segments, dec_index_x, dec_index_y}, 0);
    checkOutput("reset_outputs1", {tx_data1, tx_valid1, busy1, done1, dec_segments1, dec_index_x1, dec_index_y1}, 0);
    @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] frame with tx_ready held high");
    base = accept_count;
    applyStimulus(DIGITS_012345);
    checkOutput("busy_after_start", busy, 1);
    checkOutput("valid_before_latency", tx_valid, 0);
    @(posedge clk);
    #1;
    checkOutput("first_valid_latency", tx_valid, 1);
    wait_done(1, 2000);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("frame_a_bytes", accept_count - base, 384);
    checkOutput("frame_a_busy_low", busy, 0);
    checkOutput("frame_a_queue_empty", exp_q.size(), 0);

    $display("[TB] frame with random stalls");
    base = accept_count;
    stall_en = 1'b1;
    applyStimulus(DIGITS_012345);
    wait_done(2, 4000);
    stall_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("frame_b_bytes", accept_count - base, 384);
    checkOutput("frame_b_queue_empty", exp_q.size(), 0);

    $display("[TB] snapshot isolation and start while busy");
    base = accept_count;
    applyStimulus(DIGITS_012345);
    wait_accepts(base + 50, 500);
    segments_in = DIGITS_ALT;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(3, 2000);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("frame_c_bytes", accept_count - base, 384);
    checkOutput("frame_c_single_done", done_count, 3);
    checkOutput("frame_c_no_requeue", busy, 0);
    checkOutput("frame_c_queue_empty", exp_q.size(), 0);

    $display("[TB] reset in mid-frame");
    base = accept_count;
    applyStimulus(DIGITS_ALT);
    wait_accepts(base + 100, 500);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("abort_outputs", {tx_data, tx_valid, busy, done, dec_segments, dec_index_x, dec_index_y}, 0);
    exp_q.delete();
    repeat (5) @(posedge clk);
    #1;
    checkOutput("abort_no_done", done_count, 3);
    @(negedge clk);
    reset_n = 1'b1;
    base = accept_count;
    applyStimulus(DIGITS_012345);
    wait_done(4, 2000);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("frame_d_bytes", accept_count - base, 384);
    checkOutput("frame_d_queue_empty", exp_q.size(), 0);

    $display("[TB] single blank digit");
    applyStimulus1(8'h00);
    for (int c = 0; c < 500 && done1_count < 1; c++) @(posedge clk);
    checkOutput("frame_e_done", done1_count, 1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("frame_e_bytes", accept1_count, 64);
    checkOutput("frame_e_queue_empty", exp1_q.size(), 0);
    checkOutput("frame_e_busy_low", busy1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
